// File: rtl/vector_data_ram.sv
// vector_data_ram: byte-enabled 256-bit line memory on the processor *_RAM port.
// After reset a clear engine writes zero to every line (state INIT) before the
// memory accepts requests (state RUN). Reads return after exactly one cycle.
// Optional feature macro: VECTOR_DATA_RAM_BYPASS_EN forwards same-cycle write
// lanes into the read data; when undefined the read returns the pre-write line.
//
// Handshake: there is no backpressure. While ready=1, a request presented on an
// edge is always accepted; rvalid=1 in the following cycle marks readData as the
// result of the read accepted on that edge. While ready=0 requests are ignored.
module vector_data_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rden,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       byteena,
    input  logic [255:0]      writeData,
    output logic [255:0]      readData,
    output logic              rvalid,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [255:0]        read_data_q, read_data_d;
    logic                rvalid_q, rvalid_d;
    logic                ready_q, ready_d;

    logic [255:0]        mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_be;
    logic [255:0]        mem_wdata;
    logic [255:0]        old_line;
    logic [255:0]        rd_line;

    // Select who owns the array write port: the clear engine in INIT, the
    // processor in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_be    = '0;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (wren) begin
            mem_we    = 1'b1;
            mem_addr  = address;
            mem_be    = byteena;
            mem_wdata = writeData;
        end
    end

    // Byte-lane array write; anything presented on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < 32; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read path: old array line, optionally merged with the same-cycle write.
    always_comb begin
        old_line = mem[address];
        rd_line  = old_line;
`ifdef VECTOR_DATA_RAM_BYPASS_EN
        for (int i = 0; i < 32; i++) begin
            if (wren && byteena[i]) begin
                rd_line[8*i +: 8] = writeData[8*i +: 8];
            end
        end
`endif
    end

    // Next-state logic for the clear engine, read register and status flags.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        read_data_d = read_data_q;
        rvalid_d    = 1'b0;
        ready_d     = ready_q;
        case (state_q)
            ST_INIT: begin
                // The last clear write finishes this edge; the counter stays put.
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (rden) begin
                    read_data_d = rd_line;
                    rvalid_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FSM and registered outputs with synchronous reset back into INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            clr_addr_q  <= '0;
            read_data_q <= '0;
            rvalid_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            read_data_q <= read_data_d;
            rvalid_q    <= rvalid_d;
            ready_q     <= ready_d;
        end
    end

    assign readData = read_data_q;
    assign rvalid   = rvalid_q;
    assign ready    = ready_q;

endmodule

// File: doc/vector_data_ram.md
# vector_data_ram

Byte-enabled 256-bit data memory on the processor's `*_RAM` port, directly downstream of the vector load/store unit in the datapath's memory stage. It consumes `address_RAM`, `byteena_RAM`, `writeData_RAM`, `rden_RAM` and `wren_RAM`, and returns `readData_RAM` with a fixed one-cycle latency. After reset, a built-in clear engine zeroes every line before requests are accepted, so the processor never reads uninitialised vector data.

## Interface
Parameters:
- `ADDR_W`, default 14: line-address width; depth = 2^ADDR_W lines of 256 bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rden`  in  1  read request for `address`.
- `wren`  in  1  write request for `address`.
- `address`  in  ADDR_W  line address.
- `byteena`  in  32  per-byte write enable; bit i gates `writeData[8i+7:8i]`.
- `writeData`  in  256  write line.
- `readData`  out  256  registered read line.
- `rvalid`  out  1  `readData` updated by a read accepted on the previous edge.
- `ready`  out  1  clear complete; requests are accepted.

## Operation
- Storage: array of 2^ADDR_W × 256 bits, written per byte lane.
- FSM states: INIT, RUN.
  - `reset`=1 → INIT; clear counter `clr_addr`=0.
  - Reset values: `readData`=0, `rvalid`=0, `ready`=0.
- INIT:
  - Each edge writes an all-zero line at `clr_addr` and increments it.
  - When the write at `clr_addr`=2^ADDR_W−1 completes, go to RUN. The counter does not wrap further.
  - `rden`, `wren`, `address`, `byteena` and `writeData` are ignored: no array write, `rvalid` stays 0, `readData` holds 0.
- RUN, on each edge:
  - Write (`wren`=1): lane i is updated only if `byteena[i]`=1. `byteena`=0 changes nothing.
  - Read (`rden`=1): `readData` ← line at `address`; `rvalid` ← 1.
  - No read (`rden`=0): `rvalid` ← 0; `readData` holds its last value.
- Simultaneous `rden` and `wren` to the same address, in the same cycle:
  - Without bypass: `readData` returns the pre-write line.
  - With bypass: see Configuration.
- Read in the cycle after a write to the same address: always returns the written data. The array has already committed.
- Reset asserted mid-RUN or mid-INIT:
  - Aborts all activity and re-enters INIT from `clr_addr`=0.
  - A write presented on the reset edge is dropped.
  - Array contents are fully cleared again.

## Timing
- Read latency: exactly 1 cycle. A request on edge N gives `readData`/`rvalid` valid after edge N, usable in cycle N+1.
- Write latency: committed at the request edge; visible to a read issued on the next edge.
- Throughput: one read plus one write per cycle, no stalls in RUN.
- `ready` rises after exactly 2^ADDR_W edges with `reset`=0, counting from the first such edge.
- Once high, `ready` stays high until the next reset.
- `rvalid` is a 1-cycle pulse per accepted read; back-to-back reads hold it high.

## Configuration
- `VECTOR_DATA_RAM_BYPASS_EN` defined:
  - Same-cycle, same-address `rden`+`wren` returns the merged line: byte i = `writeData` lane if `byteena[i]`, else the old array byte.
  - Adds a 256-bit lane mux on the read path.
- Undefined: the same case returns the old array line (read-before-write). No forwarding logic is generated.

## Test plan
All scenarios use ADDR_W=4.
- Clear sequence: hold `reset` 2 cycles, release; `ready`=0 for 16 edges, then 1. Reading lines 0..15 gives all zeros with `rvalid`=1 one cycle after each request.
- Byte-lane write: in RUN, write line 3 with `byteena`=32'h0000_000F and `writeData`=all 0xAA; read line 3 → bytes 0–3 = 0xAA, bytes 4–31 = 0x00.
- Full write/readback: write line 15 with `byteena`=32'hFFFF_FFFF and an incrementing byte pattern 0x00..0x1F; read on the next edge → identical line. `rvalid` is high for exactly one cycle.
- Same-cycle RAW on line 5, which holds all 0x11; write all 0x22 with `byteena`=32'h0000_00FF plus a read of line 5:
  - bypass build → bytes 0–7 = 0x22, rest 0x11;
  - non-bypass build → all 0x11.
- Requests during INIT: issue `wren`, line 2, all 0xFF at edge 3 after reset; after `ready`, read line 2 → all zeros. `rvalid` stayed 0 throughout INIT.
- Reset mid-operation: write line 7 = all 0x5A, assert `reset` for 1 cycle during RUN. `ready` drops to 0 for 16 edges; afterwards line 7 reads all zeros and `readData` was 0 immediately after reset.
